// File: rtl/register_write_arbiter.sv
// register_write_arbiter: shares the register-file write port between the ALU (port 0) and load (port 1) writebacks.
// Define REG_WRITE_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module register_write_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_asynchronous,
    input  logic         inp_valid0,
    input  logic         inp_valid1,
    input  logic [3:0]   inp_address0,
    input  logic [3:0]   inp_address1,
    input  logic [W-1:0] inp_data0,
    input  logic [W-1:0] inp_data1,
    output logic         out_ready0,
    output logic         out_ready1,
    input  logic [3:0]   inp_read_address0,
    input  logic [3:0]   inp_read_address1,
    output logic         out_hazard0,
    output logic         out_hazard1,
    output logic         out_write_enable,
    output logic [3:0]   out_write_address,
    output logic [W-1:0] out_write_data,
    output logic         out_r15_drop
);

    logic         grant0;
    logic         grant1;
    logic         xfer;
    logic [3:0]   sel_addr;
    logic [W-1:0] sel_data;

    logic         we_q,    we_d;
    logic [3:0]   waddr_q, waddr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         drop_q,  drop_d;

`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // On contention the port that did not win last time is granted.
    always_comb begin
        grant0 = inp_valid0 & (~inp_valid1 | last_grant_q);
        grant1 = inp_valid1 & (~inp_valid0 | ~last_grant_q);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = grant1;
        end
    end

    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    always_comb begin
        grant0 = inp_valid0;
        grant1 = inp_valid1 & ~inp_valid0;
    end
`endif

    assign out_ready0 = grant0 & ~reset_asynchronous;
    assign out_ready1 = grant1 & ~reset_asynchronous;
    assign xfer       = out_ready0 | out_ready1;
    assign sel_addr   = grant1 ? inp_address1 : inp_address0;
    assign sel_data   = grant1 ? inp_data1    : inp_data0;

    // R15 requests are accepted but never reach the register file; address/data hold.
    always_comb begin
        we_d    = 1'b0;
        drop_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (xfer) begin
            if (sel_addr == 4'hF) begin
                drop_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            drop_q  <= drop_d;
        end
    end

    function automatic logic hazard_for(input logic [3:0] ra);
        logic hit;
        hit = (inp_valid0 && (inp_address0 == ra)) ||
              (inp_valid1 && (inp_address1 == ra)) ||
              (we_q       && (waddr_q      == ra));
        return hit && (ra != 4'hF);
    endfunction

    assign out_hazard0 = hazard_for(inp_read_address0);
    assign out_hazard1 = hazard_for(inp_read_address1);

    assign out_write_enable  = we_q;
    assign out_write_address = waddr_q;
    assign out_write_data    = wdata_q;
    assign out_r15_drop      = drop_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed self-checking bench for register_write_arbiter; honours REG_WRITE_ARB_ROUND_ROBIN_EN.
module tb_register_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [3:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [3:0]  ra0 = '0, ra1 = '0;
    logic        rdy0, rdy1, hz0, hz1, we, drop;
    logic [3:0]  waddr;
    logic [31:0] wdata;

    int tests = 0;
    int fails = 0;

    register_write_arbiter #(.W(32)) dut (
        .clk                (clk),
        .reset_asynchronous (rst),
        .inp_valid0         (v0),
        .inp_valid1         (v1),
        .inp_address0       (a0),
        .inp_address1       (a1),
        .inp_data0          (d0),
        .inp_data1          (d1),
        .out_ready0         (rdy0),
        .out_ready1         (rdy1),
        .inp_read_address0  (ra0),
        .inp_read_address1  (ra1),
        .out_hazard0        (hz0),
        .out_hazard1        (hz1),
        .out_write_enable   (we),
        .out_write_address  (waddr),
        .out_write_data     (wdata),
        .out_r15_drop       (drop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset;
        v0 = 1'b0; v1 = 1'b0; ra0 = '0; ra1 = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        v0 = 1'b1; a0 = 4'd4; d0 = 32'h0BAD_F00D;
        #2;
        tests++;
        if (rdy0 !== 1'b0) begin
            fails++; $display("FAIL reset_ready0: got %0b expected 0", rdy0);
        end
        do_reset;
        #1;
        tests++;
        if (we !== 1'b0 || waddr !== 4'd0 || wdata !== 32'd0 || drop !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got we=%0b addr=%0h data=%0h drop=%0b expected 0/0/0/0",
                     we, waddr, wdata, drop);
        end
    endtask

    task automatic test_single;
        do_reset;
        @(posedge clk); #1;
        v0 = 1'b1; a0 = 4'd3; d0 = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
            fails++; $display("FAIL single_ready: got %0b%0b expected 10", rdy0, rdy1);
        end
        @(posedge clk); #1;
        v0 = 1'b0;
        tests++;
        if (we !== 1'b1 || waddr !== 4'd3 || wdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL single_write: got we=%0b addr=%0h data=%0h expected 1/3/deadbeef", we, waddr, wdata);
        end
        @(posedge clk); #1;
        tests++;
        if (we !== 1'b0 || waddr !== 4'd3 || wdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL single_idle: got we=%0b addr=%0h data=%0h expected 0/3/deadbeef", we, waddr, wdata);
        end
    endtask

    task automatic test_contention;
        int          exp_port;
        logic [3:0]  exp_addr;
        logic [31:0] exp_data;
        do_reset;
        @(posedge clk); #1;
        v0 = 1'b1; a0 = 4'd1; d0 = 32'h11;
        v1 = 1'b1; a1 = 4'd2; d1 = 32'h22;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
            exp_port = k % 2;
`else
            exp_port = 0;
`endif
            exp_addr = (exp_port == 1) ? 4'd2 : 4'd1;
            exp_data = (exp_port == 1) ? 32'h22 : 32'h11;
            tests++;
            if (rdy0 !== (exp_port == 0) || rdy1 !== (exp_port == 1)) begin
                fails++;
                $display("FAIL contention_grant%0d: got %0b%0b expected port %0d", k, rdy0, rdy1, exp_port);
            end
            @(posedge clk); #1;
            tests++;
            if (we !== 1'b1 || waddr !== exp_addr || wdata !== exp_data) begin
                fails++;
                $display("FAIL contention_write%0d: got we=%0b addr=%0h data=%0h expected 1/%0h/%0h",
                         k, we, waddr, wdata, exp_addr, exp_data);
            end
            #1;
        end
`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
        v0 = 1'b0; v1 = 1'b0;
`else
        v0 = 1'b0;
        #1;
        tests++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b1) begin
            fails++; $display("FAIL fixed_port1_grant: got %0b%0b expected 01", rdy0, rdy1);
        end
        @(posedge clk); #1;
        v1 = 1'b0;
        tests++;
        if (we !== 1'b1 || waddr !== 4'd2 || wdata !== 32'h22) begin
            fails++;
            $display("FAIL fixed_port1_write: got we=%0b addr=%0h data=%0h expected 1/2/22", we, waddr, wdata);
        end
`endif
    endtask

    task automatic test_r15;
        @(posedge clk); #1;
        v1 = 1'b1; a1 = 4'hF; d1 = 32'h1234;
        ra0 = 4'hF; ra1 = 4'hF;
        #1;
        tests++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
            fails++; $display("FAIL r15_ready: got %0b%0b expected 01", rdy0, rdy1);
        end
        tests++;
        if (hz0 !== 1'b0 || hz1 !== 1'b0) begin
            fails++; $display("FAIL r15_hazard_req: got %0b%0b expected 00", hz0, hz1);
        end
        @(posedge clk); #1;
        v1 = 1'b0;
        tests++;
        if (we !== 1'b0 || drop !== 1'b1 || waddr !== 4'd2 || wdata !== 32'h22) begin
            fails++;
            $display("FAIL r15_drop: got we=%0b drop=%0b addr=%0h data=%0h expected 0/1/2/22", we, drop, waddr, wdata);
        end
        @(posedge clk); #1;
        tests++;
        if (drop !== 1'b0) begin
            fails++; $display("FAIL r15_pulse: got %0b expected 0", drop);
        end
    endtask

    task automatic test_hazard;
        @(posedge clk); #1;
        ra0 = 4'd5; ra1 = 4'd6;
        v1 = 1'b1; a1 = 4'd5; d1 = 32'h55;
        #1;
        tests++;
        if (hz0 !== 1'b1 || hz1 !== 1'b0) begin
            fails++; $display("FAIL hazard_pending: got %0b%0b expected 10", hz0, hz1);
        end
        @(posedge clk); #1;
        v1 = 1'b0;
        #1;
        tests++;
        if (we !== 1'b1 || waddr !== 4'd5 || hz0 !== 1'b1 || hz1 !== 1'b0) begin
            fails++;
            $display("FAIL hazard_outstage: got we=%0b addr=%0h hz=%0b%0b expected 1/5/10", we, waddr, hz0, hz1);
        end
        @(posedge clk); #1;
        tests++;
        if (we !== 1'b0 || hz0 !== 1'b0) begin
            fails++; $display("FAIL hazard_cleared: got we=%0b hz0=%0b expected 0/0", we, hz0);
        end
        v0 = 1'b1; a0 = 4'd6; d0 = 32'h66;
        ra0 = 4'd7;
        #1;
        tests++;
        if (hz1 !== 1'b1 || hz0 !== 1'b0) begin
            fails++; $display("FAIL hazard_port0: got %0b%0b expected 01", hz0, hz1);
        end
        @(posedge clk); #1;
        v0 = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        v0 = 1'b1; a0 = 4'd7; d0 = 32'h77;
        @(posedge clk); #1;
        tests++;
        if (we !== 1'b1 || waddr !== 4'd7) begin
            fails++; $display("FAIL midreset_pre: got we=%0b addr=%0h expected 1/7", we, waddr);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (we !== 1'b0 || waddr !== 4'd0 || wdata !== 32'd0 || drop !== 1'b0 || rdy0 !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: got we=%0b addr=%0h data=%0h drop=%0b rdy0=%0b expected 0/0/0/0/0",
                     we, waddr, wdata, drop, rdy0);
        end
        v0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (we !== 1'b0 || waddr !== 4'd0) begin
            fails++; $display("FAIL midreset_after: got we=%0b addr=%0h expected 0/0", we, waddr);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_r15;
        test_hazard;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Shares the register file's single write port between two writeback requesters: port 0 (ALU result) and port 1 (memory load result). It uses a valid/ready handshake and a one-stage registered output. It sits between the execute/memory stages and the register file's `write_enable` / `inp_write_address0` / `inp_write_data` inputs. It also reports read-after-write hazards for both read addresses, so the controller can stall decode.

## Interface

**Parameters**
- `W`, default 32: data width; matches the register file.

**Ports**
- `clk`  in  1  rising-edge clock.
- `reset_asynchronous`  in  1  asynchronous, active-high reset.
- `inp_valid0`, `inp_valid1`  in  1  write request from port 0 / port 1.
- `inp_address0`, `inp_address1`  in  4  destination register for port 0 / port 1.
- `inp_data0`, `inp_data1`  in  W  write data for port 0 / port 1.
- `out_ready0`, `out_ready1`  out  1  request accepted this cycle (combinational).
- `inp_read_address0`, `inp_read_address1`  in  4  decode-stage read addresses.
- `out_hazard0`, `out_hazard1`  out  1  the read address has a write that is not yet committed.
- `out_write_enable`  out  1  drives the register file `write_enable`.
- `out_write_address`  out  4  drives the register file `inp_write_address0`.
- `out_write_data`  out  W  drives the register file `inp_write_data`.
- `out_r15_drop`  out  1  one-cycle pulse: an accepted request targeted R15 and was discarded.

## Operation

- **Handshake**
  - A transfer occurs on port i at a rising edge where `inp_valid_i & out_ready_i`.
  - A requester holds valid, address and data stable until that transfer.
  - Dropping valid before acceptance is illegal.
- **Grant**: at most one `out_ready` is high per cycle. `out_ready_i` is high only if `inp_valid_i` is high. If any request is valid, one request is granted that same cycle.
- **Arbitration**
  - Only one port valid: that port is granted.
  - Both ports valid: the policy is set in Configuration.
  - `last_grant` register: updated to the granted port on each transfer.
- **Output stage**
  - On a transfer with address 0..14, the output stage loads `out_write_enable=1` with the request's address and data.
  - With no transfer, `out_write_enable` goes to 0. Address and data hold their last values.
- **R15 protection**: R15 is the PC and is written only through its dedicated input.
  - A request to address 15 is still accepted (ready asserted normally).
  - It is not forwarded: `out_write_enable=0` next cycle.
  - `out_r15_drop` pulses high for that one cycle.
- **Same address on both ports**: handled as two sequential grants. Both writes commit in grant order, and the last one granted wins.
- **Hazard**: `out_hazard_k` is high when `inp_read_address_k` equals any of:
  - `inp_address0` while `inp_valid0` is high;
  - `inp_address1` while `inp_valid1` is high;
  - `out_write_address` while `out_write_enable` is high.
  - Address 15 never raises a hazard.
  - Purely combinational.

## Timing

- **Reset values** (asynchronous): `out_write_enable=0`, `out_write_address=0`, `out_write_data=0`, `out_r15_drop=0`, `last_grant=1` (port 0 wins the first contention).
- `out_ready*` and `out_hazard*` are combinational. During reset, `out_ready*` is forced to 0.
- **Latency**
  - A transfer at edge N gives `out_write_enable` high in cycle N..N+1.
  - The register file commits at edge N+1.
  - A read of that register returns the new value from cycle N+1 onward.
- **Throughput**: one write per cycle sustained. With both ports continuously valid, each port receives exactly one grant every 2 cycles (round-robin build).
- **Reset mid-operation**
  - An in-flight output-stage write is cancelled: enable clears immediately.
  - Requests not yet accepted are not remembered. Requesters re-present them after reset.

## Configuration

- **`REG_WRITE_ARB_ROUND_ROBIN_EN`**
  - **Defined**: on contention, the port not in `last_grant` wins. Grants alternate 0,1,0,1…
  - **Undefined**: fixed priority, port 0 always wins on contention. Port 1 waits until `inp_valid0` is low. `last_grant` is not implemented.
  - Handshake, latency and hazard behaviour are identical in both builds.

## Test plan

- **Reset, then single request**
  - Stimulus: reset; `inp_valid0=1`, `addr0=3`, `data0=0xDEADBEEF` for one cycle.
  - Required: `out_ready0=1` that cycle; next cycle `out_write_enable=1`, `out_write_address=3`, `out_write_data=0xDEADBEEF`; enable low the cycle after.
- **Contention, round-robin build**
  - Stimulus: both ports valid continuously (port 0: addr 1 / 0x11; port 1: addr 2 / 0x22) for 4 cycles.
  - Required grant order: 0,1,0,1. Output addresses 1,2,1,2 with matching data.
- **Contention, fixed-priority build**
  - Stimulus: same as above.
  - Required: port 0 granted 4 times, `out_ready1` stays 0; drop `inp_valid0`, then port 1 is granted the next cycle.
- **R15 drop**
  - Stimulus: `inp_valid1=1`, `addr1=15`, `data1=0x1234`.
  - Required: `out_ready1=1`; next cycle `out_write_enable=0`, `out_r15_drop=1`; `out_hazard*` stays 0 for read address 15.
- **Hazard coverage**
  - Stimulus: `inp_read_address0=5`, port 1 valid to addr 5.
  - Required: `out_hazard0=1` while pending and during the output-stage cycle; 0 one cycle after commit.
  - Required: `out_hazard1=0` when `inp_read_address1=6`.
- **Reset mid-operation**
  - Stimulus: a transfer to addr 7 at edge N; assert `reset_asynchronous` in the middle of cycle N+1.
  - Required: `out_write_enable` drops immediately (asynchronous); all outputs at reset values; no write to R7.
